// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FSM-sequenced datapath, handshaked instruction/data memories,
// HALT/illegal stop, registered {Z,N,C,V} flags and a debug PC.
//
// state  | meaning
// FETCH  | request imem[pc], latch IR on ready
// DECODE | latch A = reg[rs], B = reg[rt]
// EXEC   | ALU/flags, branch/jump resolve, or route to MEM/WB/HALT
// MEM    | data access, held until dmem ready
// WB     | write rd, advance pc
// HALT   | stopped until reset, no requests
module cpu_multicycle #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [15:0]       i_imem_rdata,
    input  logic              i_imem_ready,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_ready,
    output logic              o_halted,
    output logic              o_illegal,
    output logic [3:0]        o_flags,
    output logic [ADDR_W-1:0] o_dbg_pc
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int MSB = DATA_W - 1;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] r_regs [8];
    logic [3:0]        r_flags;
    logic              r_halted;
    logic              r_illegal;

    logic [3:0]        w_op;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [2:0]        w_rd;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_ldi;
    logic [ADDR_W-1:0] w_boff;
    logic [ADDR_W-1:0] w_jmp;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_opnd_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_c;
    logic              w_v;
    logic [3:0]        w_flags_next;

    assign w_op     = r_ir[15:12];
    assign w_rs     = r_ir[8:6];
    assign w_rt     = r_ir[5:3];
    assign w_rd     = r_ir[2:0];
    // Size casts give sign-extension for signed fields and plain truncation/zero-fill otherwise.
    assign w_imm    = DATA_W'($signed(r_ir[11:9]));
    assign w_ldi    = DATA_W'(r_ir[11:3]);
    assign w_boff   = ADDR_W'($signed({r_ir[11:9], r_ir[2:0]}));
    assign w_jmp    = ADDR_W'(r_ir[11:0]);
    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_comb begin
        w_opnd_b  = (w_op == OP_ADDI) ? w_imm : r_b;
        w_sum     = {1'b0, r_a} + {1'b0, w_opnd_b};
        w_diff    = {1'b0, r_a} - {1'b0, r_b};
        w_alu_res = w_sum[DATA_W-1:0];
        w_c       = 1'b0;
        w_v       = 1'b0;
        case (w_op)
            OP_ADD, OP_ADDI: begin
                w_c = w_sum[DATA_W];
                w_v = (r_a[MSB] == w_opnd_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_c       = w_diff[DATA_W];
                w_v       = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_LDI:  w_alu_res = w_ldi;
            default: ;
        endcase
        w_flags_next = {(w_alu_res == '0), w_alu_res[MSB], w_c, w_v};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_pc      <= ADDR_W'(RESET_PC);
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_flags   <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_imem_ready) begin
                        r_ir    <= i_imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_regs[w_rs];
                    r_b     <= r_regs[w_rt];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            r_res   <= w_alu_res;
                            r_flags <= w_flags_next;
                            r_state <= S_WB;
                        end
                        OP_LDI: begin
                            r_res   <= w_alu_res;
                            r_state <= S_WB;
                        end
                        OP_LD, OP_ST: r_state <= S_MEM;
                        OP_NOP: begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        OP_BEQ: begin
                            r_pc    <= (r_a == r_b) ? (w_pc_inc + w_boff) : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        OP_JMP: begin
                            r_pc    <= w_jmp;
                            r_state <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_halted  <= 1'b1;
                            r_illegal <= 1'b1;
                            r_state   <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (i_dmem_ready) begin
                        if (w_op == OP_LD) begin
                            r_res   <= i_dmem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != 3'd0) r_regs[w_rd] <= r_res;
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Requests are gated by reset so nothing is issued during the reset cycle itself.
    assign o_imem_req   = (r_state == S_FETCH) && !i_reset;
    assign o_imem_addr  = r_pc;
    assign o_dmem_req   = (r_state == S_MEM) && !i_reset;
    assign o_dmem_we    = (w_op == OP_ST);
    assign o_dmem_addr  = ADDR_W'(r_a);
    assign o_dmem_wdata = r_b;
    assign o_halted     = r_halted;
    assign o_illegal    = r_illegal;
    assign o_flags      = r_flags;
    assign o_dbg_pc     = r_pc;
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle 8-bit core.
- Data width and address width are generic.
- Instruction and data memories sit outside the core behind req/ready handshakes, so wait states are tolerated.
- The core adds an FSM-sequenced datapath, a HALT instruction with a `halted` status output, registered flags, and a debug PC.

Parameters:
- DATA_W, 8, datapath and register width (4..32).
- ADDR_W, 8, PC and data-address width (4..16).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (equals pc).
- imem_rdata  in  16  instruction word; valid when imem_ready=1.
- imem_ready  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data; valid when dmem_ready=1.
- dmem_ready  in  1  data access complete.
- halted  out  1  core stopped (HALT or illegal opcode).
- illegal  out  1  stopped because of an undefined opcode.
- flags  out  4  registered {Z,N,C,V}.
- dbg_pc  out  ADDR_W  current pc.

Behaviour:

Instruction format:
- Fields: op=[15:12], rs=[8:6], rt=[5:3], rd=[2:0].
- Registers r0..r7 are DATA_W wide. r0 reads as 0; writes to r0 are discarded.

Opcodes:
- 0 NOP.
- 1 ADD: rd = rs + rt.
- 2 SUB: rd = rs - rt.
- 3 AND: rd = rs & rt.
- 4 OR: rd = rs | rt.
- 5 ADDI: rd = rs + sext(instr[11:9]).
- 6 LDI: rd = zext(instr[11:3]), truncated to DATA_W.
- 7 LD: rd = mem[rs[ADDR_W-1:0]], address zero-extended if DATA_W < ADDR_W.
- 8 ST: mem[rs] = rt.
- 9 BEQ: if rs == rt, pc = pc + 1 + sext({instr[11:9], instr[2:0]}).
- A JMP: pc = instr[11:0] truncated or zero-extended to ADDR_W.
- F HALT.
- B..E are illegal.

FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ready=1.
  - ready may be sampled in the same cycle req rises.
  - On ready: IR <= imem_rdata, go to DECODE.
- DECODE: A <= reg[rs], B <= reg[rt]. Go to EXEC.
- EXEC: compute ALU result or address.
  - ALU ops and ADDI/LDI go to WB.
  - LD/ST go to MEM.
  - BEQ/JMP/NOP update pc and go to FETCH.
  - HALT sets halted=1 and goes to HALT.
  - Illegal opcode sets halted=1, illegal=1, goes to HALT.
- MEM:
  - dmem_req=1, with dmem_we, dmem_addr and dmem_wdata held stable until dmem_ready=1.
  - LD: latch dmem_rdata, go to WB.
  - ST: pc += 1, go to FETCH.
- WB: write rd, pc += 1, go to FETCH.
- HALT: absorbing until reset. No requests issued; pc frozen at the HALT address.

Cycle counts with zero wait states:
- ALU/ADDI/LDI: 4 cycles.
- LD: 5 cycles.
- ST: 4 cycles.
- BEQ/JMP/NOP: 3 cycles.
- Each cycle that ready is low adds one cycle.

Flags:
- Updated in EXEC by ADD, SUB, AND, OR, ADDI only; all other instructions leave them unchanged.
- Z = result == 0.
- N = result MSB.
- ADD/ADDI: C = carry out; V = signed overflow.
- SUB: C = borrow, i.e. 1 when rs < rt unsigned; V = signed overflow.
- AND/OR: C = 0, V = 0.

Arithmetic:
- Everything is modulo 2^DATA_W.
- pc increment and branch target are modulo 2^ADDR_W, so pc wraps from max to 0.

Reset:
- pc = RESET_PC, state = FETCH, registers = 0, flags = 0, halted = 0, illegal = 0.
- imem_req = 0 and dmem_req = 0 during the reset cycle.
- imem_req asserts in the first cycle after reset deasserts.
- Reset during a pending memory wait drops req on the next edge, and the in-flight instruction has no architectural effect.

Outputs:
- All handshake outputs are combinational from the state plus registered IR/A/B/pc only.
- There is no path from ready to addr or data.

Test Plan:
- Reset release, zero-wait memory, program `LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT` -> r3 = 8, flags = 0000, halted=1 at cycle 15, dbg_pc = 3, no requests afterwards.
- DATA_W=8, r1=0x7F, r2=0x01, ADD -> result 0x80, flags {Z,N,C,V} = 0101. Then SUB r4,r0,r2 -> 0xFF, flags 0110.
- ST r2 to address r1=0x10, then LD r5 from 0x10, with dmem_ready delayed 3 cycles -> dmem_addr and dmem_wdata stable during the wait, r5 = stored value, LD takes 8 cycles.
- BEQ with equal registers and offset -2 at pc=6 -> pc=5. With unequal registers -> pc=7. JMP at ADDR_W=4 with instr[11:0]=0x013 -> pc=3.
- imem_ready held low for 5 cycles, then reset asserted -> imem_req low the next cycle, pc = RESET_PC, r1..r7 unchanged at 0.
- Opcode 0xC fetched -> halted=1, illegal=1, register file and flags unchanged. Writing to r0 via ADD r0 -> r0 still reads 0.
